column_window_reader: RTL and testbench
=======================================

// Module: column_window_reader
// PURPOSE
//  Read-side sequencer for the pixel BRAMs. Byte-wise loading puts one image column in each
//  32-bit word: lane n = row n, word k = column k. This block walks the columns through the
//  32-bit read port (1-cycle latency) and keeps the last three columns.
//  It emits 3x3 pixel windows over a valid/ready handshake to the downstream filter stage.
// PARAMETERS
//  IMG_COLS   12  columns per frame = words read per frame; must be >= 3
//  ADDR_W     9   width of BRAM read address (32-bit port)
//  BASE_ADDR  1   word address of column 0
// PORTS
//  CLK        in   1       single clock; all logic on rising edge
//  RESET      in   1       asynchronous, active-low reset
//  start      in   1       begin a frame; sampled only in IDLE
//  row_sel    in   1       0: rows 0..2 (lanes 0,1,2); 1: rows 1..3 (lanes 1,2,3); latched on start
//  enb        out  1       BRAM read enable
//  addrb      out  ADDR_W  BRAM read word address
//  doutb      in   32      BRAM read data, valid the cycle after enb=1; lane n = doutb[8n+7:8n]
//  win_valid  out  1       window outputs valid
//  win_ready  in   1       downstream accepts window when win_valid & win_ready
//  win_col    out  ADDR_W  column index (0-based) of the window's rightmost column
//  out1..out9 out  8 each  window, row-major: out1..3 = top row, oldest->newest column;
//                          out4..6 = middle row; out7..9 = bottom row
//  complete   out  1       one-cycle pulse after last window accepted
// BEHAVIOUR
//  Reset (RESET=0, any state, any time): state=IDLE; enb=0, addrb=0, win_valid=0, win_col=0,
//   out1..out9=0, complete=0; column regs and counters cleared; a frame in progress is abandoned.
//  FSM: IDLE -> READ -> CAPT -> (READ | OUT) -> ... -> DONE -> IDLE
//  IDLE: start=1 -> latch row_sel, col_cnt=0, go READ. start ignored in every other state.
//  READ: enb=1, addrb=BASE_ADDR+col_cnt (ADDR_W wrap, no saturation); next CAPT.
//   enb=0 in all other states.
//  CAPT: doutb valid; shift column regs: c0<=c1, c1<=c2, c2<=selected lanes of doutb.
//   col_cnt++. If col_cnt (after increment) >= 3 -> OUT, else READ.
//  OUT: win_valid=1; outputs driven from c0/c1/c2; win_col=col_cnt-1.
//   Outputs hold stable while win_valid & !win_ready (no change, no new reads).
//   On win_valid & win_ready: col_cnt==IMG_COLS -> DONE, else READ.
//  DONE: complete=1 for exactly this cycle; next IDLE.
//  Windows per frame = IMG_COLS-2; first window covers columns 0,1,2.
//  Latency: start to first win_valid = 7 cycles (3 x READ+CAPT, +1).
//   Each later window follows acceptance by 3 cycles.
//  win_ready asserted while win_valid=0 has no effect.
//  start held high across DONE -> IDLE starts a new frame on the cycle after DONE.
//  Pixel data is passed through unmodified; no arithmetic on pixel values.
// TESTING
//  1 Reset: RESET=0 mid-OUT with win_valid=1 -> next cycle all outputs 0, enb=0, state IDLE.
//    Release RESET, pulse start -> frame restarts at addrb=BASE_ADDR.
//  2 Nominal: BRAM word k = {8'd(40+k),8'd(30+k),8'd(20+k),8'd(10+k)}, row_sel=0,
//    win_ready=1, pulse start -> 10 windows.
//    First: out1..9 = 10,11,12 / 20,21,22 / 30,31,32, win_col=2.
//    Last: win_col=11. Then complete pulses once.
//  3 Lane select: same data, row_sel=1 -> first window = 20,21,22 / 30,31,32 / 40,41,42.
//  4 Backpressure: win_ready=0 for 5 cycles on window 3 -> win_valid and out1..9 stable,
//    enb=0 throughout. After ready, next addrb=BASE_ADDR+5.
//  5 Read sequence: log enb/addrb -> exactly 12 reads, addrb = 1..12 in order, each enb high 1 cycle.
//  6 start ignored while busy: pulse start during window 4 -> no restart, 10 windows, single complete.

Source files
------------

// File: rtl/column_window_reader.sv
// Read-side sequencer for the pixel BRAMs: walks the image columns through the
// 32-bit read port and presents a sliding 3x3 pixel window over valid/ready.
module column_window_reader #(
    parameter int unsigned IMG_COLS  = 12,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned BASE_ADDR = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              row_sel,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [31:0]       doutb,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [ADDR_W-1:0] win_col,
    output logic [7:0]        out1,
    output logic [7:0]        out2,
    output logic [7:0]        out3,
    output logic [7:0]        out4,
    output logic [7:0]        out5,
    output logic [7:0]        out6,
    output logic [7:0]        out7,
    output logic [7:0]        out8,
    output logic [7:0]        out9,
    output logic              complete
);
    localparam int unsigned       CntW     = $clog2(IMG_COLS + 1);
    localparam logic [CntW-1:0]   ColsLast = CntW'(IMG_COLS);
    localparam logic [CntW-1:0]   CntThree = CntW'(3);
    localparam logic [ADDR_W-1:0] Base     = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {StIdle, StRead, StCapt, StOut, StDone} state_e;

    state_e            state_q;
    logic              sel_q;
    logic [CntW-1:0]   cnt_q;
    logic [23:0]       col0_q, col1_q, col2_q;
    logic              enb_q, valid_q, complete_q;
    logic [ADDR_W-1:0] addrb_q, win_col_q;

    logic [CntW-1:0]   cnt_d;
    logic [23:0]       lanes_d;

    assign cnt_d   = cnt_q + CntW'(1);
    // Three consecutive rows taken from the word: rows 0..2 or rows 1..3.
    assign lanes_d = sel_q ? doutb[31:8] : doutb[23:0];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= StIdle;
            sel_q      <= 1'b0;
            cnt_q      <= '0;
            col0_q     <= '0;
            col1_q     <= '0;
            col2_q     <= '0;
            enb_q      <= 1'b0;
            addrb_q    <= '0;
            valid_q    <= 1'b0;
            win_col_q  <= '0;
            complete_q <= 1'b0;
        end else begin
            complete_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        sel_q   <= row_sel;
                        cnt_q   <= '0;
                        enb_q   <= 1'b1;
                        addrb_q <= Base;
                        state_q <= StRead;
                    end
                end
                StRead: begin
                    enb_q   <= 1'b0;
                    state_q <= StCapt;
                end
                StCapt: begin
                    col0_q <= col1_q;
                    col1_q <= col2_q;
                    col2_q <= lanes_d;
                    cnt_q  <= cnt_d;
                    if (cnt_d >= CntThree) begin
                        valid_q   <= 1'b1;
                        win_col_q <= ADDR_W'(cnt_d - CntW'(1));
                        state_q   <= StOut;
                    end else begin
                        enb_q   <= 1'b1;
                        addrb_q <= Base + ADDR_W'(cnt_d);
                        state_q <= StRead;
                    end
                end
                StOut: begin
                    // Window and column registers hold until the consumer takes it.
                    if (win_ready) begin
                        valid_q <= 1'b0;
                        if (cnt_q == ColsLast) begin
                            complete_q <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            enb_q   <= 1'b1;
                            addrb_q <= Base + ADDR_W'(cnt_q);
                            state_q <= StRead;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign enb       = enb_q;
    assign addrb     = addrb_q;
    assign win_valid = valid_q;
    assign win_col   = win_col_q;
    assign complete  = complete_q;

    assign out1 = col0_q[7:0];
    assign out2 = col1_q[7:0];
    assign out3 = col2_q[7:0];
    assign out4 = col0_q[15:8];
    assign out5 = col1_q[15:8];
    assign out6 = col2_q[15:8];
    assign out7 = col0_q[23:16];
    assign out8 = col1_q[23:16];
    assign out9 = col2_q[23:16];

endmodule

// File: tb/tb_column_window_reader.sv
// Bench for column_window_reader: BRAM model, frame-level window model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_column_window_reader;
    localparam int unsigned IMG_COLS  = 12;
    localparam int unsigned ADDR_W    = 9;
    localparam int unsigned BASE_ADDR = 1;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic              start = 1'b0;
    logic              row_sel = 1'b0;
    logic              win_ready = 1'b0;
    logic [31:0]       doutb = '0;
    logic              enb, win_valid, complete;
    logic [ADDR_W-1:0] addrb, win_col;
    logic [7:0]        out1, out2, out3, out4, out5, out6, out7, out8, out9;
    logic [7:0]        outs [9];

    int n_chk = 0;
    int n_fail = 0;

    column_window_reader #(
        .IMG_COLS (IMG_COLS),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .start    (start),
        .row_sel  (row_sel),
        .enb      (enb),
        .addrb    (addrb),
        .doutb    (doutb),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .win_col  (win_col),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
        .out4     (out4),
        .out5     (out5),
        .out6     (out6),
        .out7     (out7),
        .out8     (out8),
        .out9     (out9),
        .complete (complete)
    );

    always #5 CLK = ~CLK;

    assign outs[0] = out1;
    assign outs[1] = out2;
    assign outs[2] = out3;
    assign outs[3] = out4;
    assign outs[4] = out5;
    assign outs[5] = out6;
    assign outs[6] = out7;
    assign outs[7] = out8;
    assign outs[8] = out9;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Image content: column k, row n holds 10*(n+1)+k.
    function automatic int pix(input int col, input int row);
        return 10 * (row + 1) + col;
    endfunction

    function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
        int k;
        k = int'(a) - int'(BASE_ADDR);
        return {8'(pix(k, 3)), 8'(pix(k, 2)), 8'(pix(k, 1)), 8'(pix(k, 0))};
    endfunction

    always @(posedge CLK) begin
        if (enb) doutb <= word_at(addrb);
    end

    // Frame model: which window is on offer, how many reads were issued.
    logic m_busy = 1'b0;
    logic m_sel = 1'b0;
    int   m_acc = 0;
    int   m_reads = 0;
    int   n_complete = 0;
    logic prev_enb = 1'b0;
    int   last_col = 0;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_busy   <= 1'b0;
            m_acc    <= 0;
            m_reads  <= 0;
            prev_enb <= 1'b0;
        end else begin
            if (enb) begin
                check("read_in_frame", int'(m_busy), 1);
                check("read_addr", int'(addrb), int'(BASE_ADDR) + m_reads);
                check("enb_single_cycle", int'(prev_enb), 0);
                m_reads <= m_reads + 1;
            end
            prev_enb <= enb;
            if (win_valid && win_ready) m_acc <= m_acc + 1;
            if (complete) begin
                check("windows_per_frame", m_acc, int'(IMG_COLS) - 2);
                check("reads_per_frame", m_reads, int'(IMG_COLS));
                m_busy     <= 1'b0;
                n_complete <= n_complete + 1;
            end else if (!m_busy && start) begin
                m_busy  <= 1'b1;
                m_sel   <= row_sel;
                m_acc   <= 0;
                m_reads <= 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (RESET) begin
            if (win_valid) begin
                check("valid_in_frame", int'(m_busy), 1);
                check("win_col", int'(win_col), m_acc + 2);
                check("no_read_while_valid", int'(enb), 0);
                for (int i = 0; i < 9; i++) begin
                    check($sformatf("out%0d", i + 1), int'(outs[i]),
                          pix(m_acc + i % 3, int'(m_sel) + i / 3));
                end
                last_col = int'(win_col);
            end else if (!m_busy) begin
                check("idle_quiet", int'({enb, win_valid, complete}), 0);
            end
        end
    end

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!win_valid && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_valid_seen"}, int'(win_valid), 1);
    endtask

    task automatic start_frame(input logic sel, output int lat);
        row_sel = sel;
        start   = 1'b1;
        lat     = 0;
        do begin
            @(negedge CLK);
            start = 1'b0;
            lat++;
        end while (!win_valid && lat < 40);
        check("first_valid_seen", int'(win_valid), 1);
    endtask

    task automatic wait_complete(input string tag);
        int n = 0;
        while (!complete && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_complete_seen"}, int'(complete), 1);
        @(negedge CLK);
        check({tag, "_complete_one_cycle"}, int'(complete), 0);
    endtask

    // Literal window check: top-left pixel t, rows +10, columns +1.
    task automatic check_win(input string tag, input int t, input int col);
        check({tag, "_win_col"}, int'(win_col), col);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("%s_out%0d", tag, i + 1), int'(outs[i]), t + 10 * (i / 3) + i % 3);
        end
    endtask

    task automatic accept_one();
        wait_valid("accept");
        win_ready = 1'b1;
        @(negedge CLK);
        win_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int c0;
        int n;

        repeat (3) @(negedge CLK);
        check("rst_enb", int'(enb), 0);
        check("rst_addrb", int'(addrb), 0);
        check("rst_valid", int'(win_valid), 0);
        check("rst_complete", int'(complete), 0);
        RESET = 1'b1;
        @(negedge CLK);

        // Nominal frame, rows 0..2.
        win_ready = 1'b1;
        c0 = n_complete;
        start_frame(1'b0, lat);
        check("latency", lat, 7);
        check_win("nominal_first", 10, 2);
        wait_complete("nominal");
        check("nominal_last_col", last_col, 11);
        repeat (3) @(negedge CLK);
        check("nominal_complete_count", n_complete - c0, 1);

        // Lane select, rows 1..3.
        start_frame(1'b1, lat);
        check_win("lanesel_first", 20, 2);
        wait_complete("lanesel");

        // Backpressure on window 3.
        win_ready = 1'b0;
        row_sel   = 1'b0;
        start     = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        accept_one();
        accept_one();
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", int'(win_valid), 1);
            check("bp_no_read", int'(enb), 0);
            check_win("bp_hold", 12, 4);
            @(negedge CLK);
        end
        win_ready = 1'b1;
        @(negedge CLK);
        n = 0;
        while (!enb && n < 10) begin
            @(negedge CLK);
            n++;
        end
        check("bp_resume_enb", int'(enb), 1);
        check("bp_resume_addr", int'(addrb), int'(BASE_ADDR) + 5);
        wait_complete("bp");

        // start during window 4 must be ignored.
        c0 = n_complete;
        row_sel = 1'b0;
        start   = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        n = 0;
        while (!(win_valid && win_col == 5) && n < 60) begin
            @(negedge CLK);
            n++;
        end
        check("busy_reached_w4", int'(win_col), 5);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_complete("busy");
        repeat (5) @(negedge CLK);
        check("busy_complete_count", n_complete - c0, 1);
        check("busy_no_restart", int'({enb, win_valid}), 0);

        // Reset in the middle of a window offer.
        win_ready = 1'b0;
        start_frame(1'b0, lat);
        RESET = 1'b0;
        #1;
        check("midrst_enb", int'(enb), 0);
        check("midrst_addrb", int'(addrb), 0);
        check("midrst_valid", int'(win_valid), 0);
        check("midrst_win_col", int'(win_col), 0);
        check("midrst_complete", int'(complete), 0);
        for (int i = 0; i < 9; i++) check($sformatf("midrst_out%0d", i + 1), int'(outs[i]), 0);
        @(negedge CLK);
        RESET     = 1'b1;
        win_ready = 1'b1;
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check("restart_enb", int'(enb), 1);
        check("restart_addr", int'(addrb), int'(BASE_ADDR));
        wait_complete("restart");

        repeat (3) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
